// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: assembles opcode/A/B from byte-serial strobed writes, holds them to an external ALU
// for EXEC_CYCLES clocks, then registers its Result/Cout with a valid flag.
module alu_operand_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       data_strobe,
  output logic [2:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic [7:0] result_out,
  output logic       cout_out,
  output logic       result_valid,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q, wr, take, exec_end;
  logic [3:0] cnt;
  // synchronizer and edge history run regardless of ena so a held strobe never re-fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_strobe};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  assign wr = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign take = ena & wr;
  assign exec_end = ena && state == EXEC && cnt == 4'd0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = take ? LOAD_A : state;
      LOAD_A:     state_nx = take ? LOAD_B : state;
      LOAD_B:     state_nx = take ? EXEC : state;
      EXEC:       state_nx = exec_end ? DONE : state;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  assign busy = state inside {LOAD_A, LOAD_B, EXEC};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_sel      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      cnt          <= '0;
      result_out   <= '0;
      cout_out     <= 1'b0;
      result_valid <= 1'b0;
    end else if (ena) begin
      if (wr && (state == IDLE || state == DONE)) alu_sel <= data_in[2:0];
      if (wr && state == DONE) result_valid <= 1'b0;
      if (wr && state == LOAD_A) alu_a <= data_in;
      if (wr && state == LOAD_B) begin
        alu_b <= data_in;
        cnt   <= 4'(EXEC_CYCLES - 1);
      end
      if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (exec_end) begin
        result_out   <= alu_result;
        cout_out     <= alu_cout;
        result_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: two sequencers (EXEC_CYCLES 1 and 4) on shared pins, each feeding an adder stub,
// checked every cycle against a transaction-level model plus table vectors and directed corner cases.
module tb_alu_operand_sequencer;
  localparam int S = 2;
  localparam int E0 = 1;
  localparam int E1 = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, data_strobe = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] sel [2];
  logic [7:0] a [2], b [2], res_in [2], res_out [2];
  logic cin [2], cout [2], valid [2], busy [2];
  always #5 clk = ~clk;
  assign {cin[0], res_in[0]} = 9'(a[0]) + 9'(b[0]);
  assign {cin[1], res_in[1]} = 9'(a[1]) + 9'(b[1]);
  alu_operand_sequencer #(.SYNC_STAGES(S), .EXEC_CYCLES(E0)) u_e1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .data_strobe(data_strobe),
    .alu_sel(sel[0]), .alu_a(a[0]), .alu_b(b[0]), .alu_result(res_in[0]), .alu_cout(cin[0]),
    .result_out(res_out[0]), .cout_out(cout[0]), .result_valid(valid[0]), .busy(busy[0]));
  alu_operand_sequencer #(.SYNC_STAGES(S), .EXEC_CYCLES(E1)) u_e4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .data_strobe(data_strobe),
    .alu_sel(sel[1]), .alu_a(a[1]), .alu_b(b[1]), .alu_result(res_in[1]), .alu_cout(cin[1]),
    .result_out(res_out[1]), .cout_out(cout[1]), .result_valid(valid[1]), .busy(busy[1]));
  // transaction model: bytes collected so far, and the enabled-edge number at which the result lands
  int ex [2] = '{E0, E1};
  int phase [2], cap [2], b_edge [2], lat [2];
  bit pend [2], pv [2];
  logic [2:0] m_sel [2];
  logic [7:0] m_a [2], m_b [2], m_res [2];
  logic m_cout [2], m_valid [2];
  logic [8:0] p_sum [2];
  logic [15:0] sh;
  int ecnt, gcnt = 0;
  int vectors = 0, errors = 0;
  bit chk = 1'b0;
  typedef struct {
    logic [7:0] op, a, b;
    logic [2:0] sel;
    logic [7:0] res;
    logic       cout;
  } vec_t;
  vec_t tbl [5];
  task automatic model_reset();
    sh = '0;
    ecnt = 0;
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; pend[i] = 1'b0; m_sel[i] = '0; m_a[i] = '0; m_b[i] = '0;
      m_res[i] = '0; m_cout[i] = 1'b0; m_valid[i] = 1'b0;
    end
  endtask
  task automatic model_step();
    logic wr_now;
    bit drop;
    wr_now = sh[S-1] & ~sh[S];
    sh = {sh[14:0], data_strobe};
    gcnt++;
    if (ena) begin
      ecnt++;
      for (int i = 0; i < 2; i++) begin
        drop = pend[i];
        if (pend[i] && ecnt == cap[i]) begin
          m_res[i] = p_sum[i][7:0]; m_cout[i] = p_sum[i][8]; m_valid[i] = 1'b1; pend[i] = 1'b0;
        end
        if (wr_now && !drop) begin
          if (phase[i] == 1) begin
            m_a[i] = data_in; phase[i] = 2;
          end else if (phase[i] == 2) begin
            m_b[i] = data_in; phase[i] = 3; pend[i] = 1'b1; cap[i] = ecnt + ex[i];
            p_sum[i] = 9'(m_a[i]) + 9'(data_in); b_edge[i] = gcnt;
          end else begin
            m_sel[i] = data_in[2:0]; m_valid[i] = 1'b0; phase[i] = 1;
          end
        end
      end
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic check_all();
    logic [29:0] got, exp;
    logic mbusy;
    for (int i = 0; i < 2; i++) begin
      mbusy = phase[i] == 1 || phase[i] == 2 || pend[i];
      got = {sel[i], a[i], b[i], res_out[i], cout[i], valid[i], busy[i]};
      exp = {m_sel[i], m_a[i], m_b[i], m_res[i], m_cout[i], m_valid[i], mbusy};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle dut%0d @%0t: got %h want %h (sel,a,b,res,cout,valid,busy)", i, $time, got, exp);
      end
      if (valid[i] && !pv[i]) lat[i] = gcnt - b_edge[i] + 1;
      pv[i] = valid[i];
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (chk) check_all();
  end
  task automatic send_byte(logic [7:0] d);
    data_in = d;
    data_strobe = 1'b1;
    repeat (S + 3) @(negedge clk);
    data_strobe = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic check_outs_zero(string name);
    for (int i = 0; i < 2; i++)
      check(name, {sel[i], a[i], b[i], res_out[i], cout[i], valid[i], busy[i]}, '0);
  endtask
  initial begin
    int h, l;
    tbl[0] = '{8'h01, 8'hC8, 8'h64, 3'd1, 8'h2C, 1'b1};
    tbl[1] = '{8'h00, 8'h0F, 8'h01, 3'd0, 8'h10, 1'b0};
    tbl[2] = '{8'hFD, 8'hFF, 8'h01, 3'd5, 8'h00, 1'b1};
    tbl[3] = '{8'hA7, 8'h80, 8'h80, 3'd7, 8'h00, 1'b1};
    tbl[4] = '{8'h02, 8'h33, 8'h44, 3'd2, 8'h77, 1'b0};
    repeat (3) @(negedge clk);
    check_outs_zero("reset_state");
    #2 rst_n = 1'b1;
    ena = 1'b1;
    chk = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      send_byte(tbl[t].op);
      if (t > 0)
        for (int i = 0; i < 2; i++) check("valid_drop_on_opcode", {valid[i], busy[i]}, 2'b01);
      send_byte(tbl[t].a);
      send_byte(tbl[t].b);
      for (int i = 0; i < 2; i++) begin
        check("tbl_operands", {sel[i], a[i], b[i]}, {tbl[t].sel, tbl[t].a, tbl[t].b});
        check("tbl_result", {cout[i], res_out[i]}, {tbl[t].cout, tbl[t].res});
        check("tbl_valid_busy", {valid[i], busy[i]}, 2'b10);
        check("tbl_latency", lat[i], ex[i] + 1);
      end
    end
    // ena low in LOAD_B: byte lost; strobe held high across ena re-assertion must not re-fire
    send_byte(8'h03);
    send_byte(8'h11);
    data_in = 8'h99;
    data_strobe = 1'b1;
    ena = 1'b0;
    repeat (S + 4) @(negedge clk);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) check("ena_b_held", {b[i], busy[i]}, {8'h44, 1'b1});
    data_strobe = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h22);
    for (int i = 0; i < 2; i++) check("ena_b_loaded", {b[i], res_out[i], valid[i]}, {8'h22, 8'h33, 1'b1});
    // second strobe lands in EXEC for the 4-cycle unit (dropped) and in DONE for the 1-cycle unit (opcode)
    send_byte(8'h00);
    send_byte(8'h0F);
    data_in = 8'h01;
    data_strobe = 1'b1;
    repeat (2) @(negedge clk);
    data_strobe = 1'b0;
    repeat (2) @(negedge clk);
    data_in = 8'h77;
    data_strobe = 1'b1;
    repeat (S + 3) @(negedge clk);
    data_strobe = 1'b0;
    repeat (8) @(negedge clk);
    check("exec_drop_e4", {sel[1], res_out[1], cout[1], valid[1], busy[1]}, {3'd0, 8'h10, 1'b0, 1'b1, 1'b0});
    check("exec_latency_e4", lat[1], 5);
    check("done_opcode_e1", {sel[0], res_out[0], valid[0], busy[0]}, {3'd7, 8'h10, 1'b0, 1'b1});
    // reset mid-load
    send_byte(8'h06);
    send_byte(8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h04);
    for (int i = 0; i < 2; i++) check("post_reset_opcode", {sel[i], a[i], busy[i]}, {3'd4, 8'h00, 1'b1});
    send_byte(8'h10);
    send_byte(8'h20);
    for (int i = 0; i < 2; i++) check("post_reset_result", {res_out[i], valid[i]}, {8'h30, 1'b1});
    // random bytes, strobe widths and ena gating against the model
    for (int n = 0; n < 150; n++) begin
      h = $urandom_range(1, 3);
      l = $urandom_range(S + 2, 6);
      data_in = 8'($urandom);
      data_strobe = 1'b1;
      for (int k = 0; k < h; k++) begin
        @(negedge clk);
        ena = $urandom_range(0, 4) != 0;
      end
      data_strobe = 1'b0;
      for (int k = 0; k < l; k++) begin
        @(negedge clk);
        ena = $urandom_range(0, 4) != 0;
      end
    end
    ena = 1'b1;
    repeat (10) @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
